// File: rtl/heading_integrator_p.sv
// Gyro heading integrator: calibrates the yaw-rate offset, then offset-compensates,
// scales and integrates yaw rate into a wrapping signed heading.
module heading_integrator_p #(
  parameter int DATA_W      = 16,
  parameter int CAL_LOG2    = 11,
  parameter int HEAD_W      = 12,
  parameter int FRAC_W      = 15,
  parameter int SCALE_NUM   = 31,
  parameter int SCALE_SHIFT = 5,
  parameter int FUSION_GAIN = 12288,
  parameter int ERR_LIM     = 8192
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              strt_cal,
  input  logic              vld,
  input  logic [DATA_W-1:0] yaw_rt,
  input  logic              lftIR,
  input  logic              rghtIR,
  input  logic              moving,
  input  logic              ld_hdg,
  input  logic [HEAD_W-1:0] hdg_val,
  output logic              cal_busy,
  output logic              cal_done,
  output logic              cal_err,
  output logic              rdy,
  output logic [HEAD_W-1:0] heading
);

  localparam int CW = DATA_W + 3;
  localparam int AW = CW + CAL_LOG2;
  localparam int IW = HEAD_W + FRAC_W;
  localparam int PW = CW + SCALE_SHIFT;

  localparam logic signed [DATA_W:0] LIM_POS = (DATA_W + 1)'(ERR_LIM);
  localparam logic signed [DATA_W:0] LIM_NEG = (DATA_W + 1)'(-ERR_LIM);
  localparam logic [IW-1:0]          FUS_POS = IW'(FUSION_GAIN);
  localparam logic [IW-1:0]          FUS_NEG = IW'(-FUSION_GAIN);
  localparam logic [PW-1:0]          SCALE_K = PW'(SCALE_NUM);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAL  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t              state_q;
  logic [CAL_LOG2-1:0] cnt_q;
  logic [AW-1:0]       acc_q;
  logic [CW-1:0]       yaw_off_q;
  logic                cal_busy_q;
  logic                cal_done_q;
  logic                cal_err_q;

  logic                v1_q, v2_q, rdy_q;
  logic [CW-1:0]       comp_q, comp_d;
  logic [CW-1:0]       scaled_q, scaled_d;
  logic [IW-1:0]       integ_q, integ_d;

  logic [CW-1:0]       yaw_sh;
  logic signed [DATA_W:0] yaw_x;
  logic                range_bad;
  logic                cal_smp;
  logic                cal_last;
  logic [AW-1:0]       acc_sum;
  logic [PW-1:0]       comp_ext;
  logic [PW-1:0]       prod;
  logic [IW-1:0]       scaled_ext;
  logic [IW-1:0]       fus;
  logic                unused_prod_lsbs;

  // S1: offset compensation (raw shifted rate while calibrating)
  assign yaw_sh = {yaw_rt, 3'b000};

  always_comb begin
    comp_d = yaw_sh;
    if (state_q == ST_RUN) begin
      comp_d = yaw_sh - yaw_off_q;
    end
  end

  assign yaw_x     = $signed({yaw_rt[DATA_W-1], yaw_rt});
  assign range_bad = (yaw_x > LIM_POS) || (yaw_x < LIM_NEG);
  assign cal_smp   = vld && (state_q == ST_CAL);
  assign cal_last  = cal_smp && (cnt_q == '1);
  assign acc_sum   = acc_q + {{CAL_LOG2{comp_d[CW-1]}}, comp_d};

  // S2: the low CW bits of (comp*SCALE_NUM)>>>SCALE_SHIFT are product bits [PW-1:SCALE_SHIFT]
  assign comp_ext         = {{SCALE_SHIFT{comp_q[CW-1]}}, comp_q};
  assign prod             = comp_ext * SCALE_K;
  assign scaled_d         = prod[PW-1:SCALE_SHIFT];
  assign unused_prod_lsbs = ^prod[SCALE_SHIFT-1:0];

  // S3: integration with guardrail fusion
  assign scaled_ext = {{(IW - CW){scaled_q[CW-1]}}, scaled_q};

  always_comb begin
    fus = '0;
    case ({lftIR, rghtIR})
      2'b10:   fus = FUS_POS;
      2'b01:   fus = FUS_NEG;
      default: fus = '0;
    endcase
  end

  always_comb begin
    integ_d = integ_q;
    if ((state_q != ST_RUN) || strt_cal) begin
      integ_d = '0;
    end else if (ld_hdg) begin
      integ_d = {hdg_val, {FRAC_W{1'b0}}};
    end else if (v2_q && moving) begin
      integ_d = integ_q + scaled_ext + fus;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      rdy_q    <= 1'b0;
      comp_q   <= '0;
      scaled_q <= '0;
      integ_q  <= '0;
    end else begin
      v1_q  <= vld;
      v2_q  <= v1_q;
      rdy_q <= v2_q;
      if (vld) begin
        comp_q <= comp_d;
      end
      if (v1_q) begin
        scaled_q <= scaled_d;
      end
      integ_q <= integ_d;
    end
  end

  // Control FSM; a restart request outranks the final calibration sample
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      yaw_off_q  <= '0;
      cal_busy_q <= 1'b0;
      cal_done_q <= 1'b0;
      cal_err_q  <= 1'b0;
    end else begin
      cal_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (strt_cal) begin
            state_q    <= ST_CAL;
            cal_busy_q <= 1'b1;
            cnt_q      <= '0;
            acc_q      <= '0;
            cal_err_q  <= 1'b0;
          end
        end
        ST_CAL: begin
          if (strt_cal) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            cal_err_q <= 1'b0;
          end else if (cal_smp) begin
            if (range_bad) begin
              cal_err_q <= 1'b1;
            end
            if (cal_last) begin
              yaw_off_q  <= acc_sum[AW-1:CAL_LOG2];
              state_q    <= ST_RUN;
              cal_busy_q <= 1'b0;
              cal_done_q <= 1'b1;
              cnt_q      <= '0;
              acc_q      <= '0;
            end else begin
              cnt_q <= cnt_q + CAL_LOG2'(1);
              acc_q <= acc_sum;
            end
          end
        end
        ST_RUN: begin
          if (strt_cal) begin
            state_q    <= ST_CAL;
            cal_busy_q <= 1'b1;
            cnt_q      <= '0;
            acc_q      <= '0;
            cal_err_q  <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          cal_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign cal_busy = cal_busy_q;
  assign cal_done = cal_done_q;
  assign cal_err  = cal_err_q;
  assign rdy      = rdy_q;
  assign heading  = integ_q[IW-1:FRAC_W];

endmodule

// File: tb/tb_heading_integrator_p.sv
// Scoreboard bench for heading_integrator_p with CAL_LOG2=3: expected heading and
// rdy cycle are pushed per sample and checked when rdy appears.
module tb_heading_integrator_p;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        strt_cal = 1'b0;
  logic        vld = 1'b0;
  logic [15:0] yaw_rt = '0;
  logic        lftIR = 1'b0;
  logic        rghtIR = 1'b0;
  logic        moving = 1'b0;
  logic        ld_hdg = 1'b0;
  logic [11:0] hdg_val = '0;
  logic        cal_busy, cal_done, cal_err, rdy;
  logic [11:0] heading;

  heading_integrator_p #(.CAL_LOG2(3)) dut (
    .clk(clk), .rst(rst), .strt_cal(strt_cal), .vld(vld), .yaw_rt(yaw_rt),
    .lftIR(lftIR), .rghtIR(rghtIR), .moving(moving), .ld_hdg(ld_hdg),
    .hdg_val(hdg_val), .cal_busy(cal_busy), .cal_done(cal_done),
    .cal_err(cal_err), .rdy(rdy), .heading(heading)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [11:0] hdg;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;
  bit          m_run = 1'b0;
  int          m_off = 0;
  logic [26:0] m_integ = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    if (mon_en && rdy === 1'b1) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL rdy_unexpected: rdy=1 at cycle %0d, required no output", cyc);
      end else begin
        e = sb.pop_front();
        if (cyc !== e.due) begin
          n_err++;
          $display("FAIL rdy_latency: rdy at cycle %0d, required cycle %0d", cyc, e.due);
        end
        n_vec++;
        if (heading !== e.hdg) begin
          n_err++;
          $display("FAIL sample_heading: got %h, required %h (cycle %0d)", heading, e.hdg, cyc);
        end
      end
    end
  end

  // Drive one sample at the current negedge and record what the bench model predicts.
  task automatic send(input logic [15:0] yaw, input bit push);
    int          c;
    int          sc;
    logic [18:0] c19;
    logic [18:0] s19;
    logic [26:0] add;
    vld    = 1'b1;
    yaw_rt = yaw;
    c   = $signed(yaw) * 8 - (m_run ? m_off : 0);
    c19 = c[18:0];
    sc  = (int'($signed(c19)) * 31) >>> 5;
    s19 = sc[18:0];
    if (m_run && moving) begin
      add = {{8{s19[18]}}, s19};
      if (lftIR && !rghtIR) add = add + 27'd12288;
      else if (rghtIR && !lftIR) add = add - 27'd12288;
      m_integ = m_integ + add;
    end
    if (push) sb.push_back('{due: cyc + 3, hdg: m_integ[26:15]});
    @(negedge clk);
    vld = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_strt();
    strt_cal = 1'b1;
    @(negedge clk);
    strt_cal = 1'b0;
    m_run   = 1'b0;
    m_integ = '0;
  endtask

  task automatic load_hdg(input logic [11:0] v);
    ld_hdg  = 1'b1;
    hdg_val = v;
    @(negedge clk);
    ld_hdg = 1'b0;
    if (m_run) m_integ = {v, 15'b0};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (cal_busy !== 1'b0) begin n_err++; $display("FAIL reset_cal_busy: got %b, required 0", cal_busy); end
    n_vec++; if (cal_done !== 1'b0) begin n_err++; $display("FAIL reset_cal_done: got %b, required 0", cal_done); end
    n_vec++; if (cal_err !== 1'b0) begin n_err++; $display("FAIL reset_cal_err: got %b, required 0", cal_err); end
    n_vec++; if (rdy !== 1'b0) begin n_err++; $display("FAIL reset_rdy: got %b, required 0", rdy); end
    n_vec++; if (heading !== 12'h000) begin n_err++; $display("FAIL reset_heading: got %h, required 000", heading); end
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_calibrate();
    pulse_strt();
    n_vec++; if (cal_busy !== 1'b1) begin n_err++; $display("FAIL cal_busy_on: got %b, required 1", cal_busy); end
    for (int i = 0; i < 8; i++) send(16'd16, 1'b1);
    m_off = 128;
    m_run = 1'b1;
    n_vec++; if (cal_done !== 1'b1) begin n_err++; $display("FAIL cal_done_pulse: got %b, required 1", cal_done); end
    n_vec++; if (cal_busy !== 1'b0) begin n_err++; $display("FAIL cal_busy_off: got %b, required 0", cal_busy); end
    @(negedge clk);
    n_vec++; if (cal_done !== 1'b0) begin n_err++; $display("FAIL cal_done_width: got %b, required 0", cal_done); end
    drain();
    n_vec++; if (heading !== 12'h000) begin n_err++; $display("FAIL cal_heading: got %h, required 000", heading); end
    n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL cal_drain: %0d pending, required 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_integrate();
    moving = 1'b1;
    for (int i = 0; i < 4096; i++) send(16'd48, 1'b1);
    drain();
    n_vec++; if (heading !== 12'd31) begin n_err++; $display("FAIL integ_heading: got %0d, required 31", heading); end
    n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL integ_drain: %0d pending, required 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_ld_priority();
    vld = 1'b1;
    yaw_rt = 16'd48;
    sb.push_back('{due: cyc + 3, hdg: 12'h155});
    @(negedge clk);
    vld = 1'b0;
    @(negedge clk);
    load_hdg(12'h155);
    drain();
    n_vec++; if (heading !== 12'h155) begin n_err++; $display("FAIL ld_priority: got %h, required 155", heading); end
  endtask

  task automatic test_fusion();
    load_hdg(12'h000);
    n_vec++; if (heading !== 12'h000) begin n_err++; $display("FAIL fus_load0: got %h, required 000", heading); end
    lftIR = 1'b1;
    for (int i = 0; i < 8; i++) send(16'd16, 1'b1);
    drain();
    n_vec++; if (heading !== 12'd3) begin n_err++; $display("FAIL fus_left: got %0d, required 3", heading); end
    lftIR = 1'b0;
    rghtIR = 1'b1;
    for (int i = 0; i < 8; i++) send(16'd16, 1'b1);
    drain();
    n_vec++; if (heading !== 12'd0) begin n_err++; $display("FAIL fus_right: got %0d, required 0", heading); end
    lftIR = 1'b1;
    for (int i = 0; i < 4; i++) send(16'd16, 1'b1);
    drain();
    n_vec++; if (heading !== 12'd0) begin n_err++; $display("FAIL fus_both: got %0d, required 0", heading); end
    lftIR = 1'b0;
    rghtIR = 1'b0;
  endtask

  task automatic test_wrap();
    load_hdg(12'h7FF);
    n_vec++; if (heading !== 12'h7FF) begin n_err++; $display("FAIL wrap_load: got %h, required 7ff", heading); end
    for (int i = 0; i < 140; i++) send(16'd48, 1'b1);
    drain();
    n_vec++; if (heading !== 12'h800) begin n_err++; $display("FAIL wrap_heading: got %h, required 800", heading); end
    moving = 1'b0;
    for (int i = 0; i < 8; i++) send(16'd48, 1'b1);
    drain();
    n_vec++; if (heading !== 12'h800) begin n_err++; $display("FAIL hold_heading: got %h, required 800", heading); end
  endtask

  task automatic test_cal_err();
    pulse_strt();
    n_vec++; if (heading !== 12'h000) begin n_err++; $display("FAIL recal_heading: got %h, required 000", heading); end
    n_vec++; if (cal_busy !== 1'b1) begin n_err++; $display("FAIL recal_busy: got %b, required 1", cal_busy); end
    load_hdg(12'h3AB);
    n_vec++; if (heading !== 12'h000) begin n_err++; $display("FAIL ld_in_cal: got %h, required 000", heading); end
    send(16'd16, 1'b1);
    send(16'd16, 1'b1);
    send(16'd9000, 1'b1);
    n_vec++; if (cal_err !== 1'b1) begin n_err++; $display("FAIL cal_err_set: got %b, required 1", cal_err); end
    for (int i = 0; i < 5; i++) send(16'd16, 1'b1);
    m_off = (7 * 128 + 72000) >>> 3;
    m_run = 1'b1;
    n_vec++; if (cal_done !== 1'b1) begin n_err++; $display("FAIL err_cal_done: got %b, required 1", cal_done); end
    send(16'd16, 1'b1);
    send(16'd16, 1'b1);
    drain();
    n_vec++; if (cal_err !== 1'b1) begin n_err++; $display("FAIL cal_err_sticky: got %b, required 1", cal_err); end
    pulse_strt();
    n_vec++; if (cal_err !== 1'b0) begin n_err++; $display("FAIL cal_err_clear: got %b, required 0", cal_err); end
  endtask

  task automatic test_restart_final();
    for (int i = 0; i < 7; i++) send(16'd400, 1'b1);
    strt_cal = 1'b1;
    send(16'd400, 1'b1);
    strt_cal = 1'b0;
    n_vec++; if (cal_done !== 1'b0) begin n_err++; $display("FAIL restart_no_done: got %b, required 0", cal_done); end
    n_vec++; if (cal_busy !== 1'b1) begin n_err++; $display("FAIL restart_busy: got %b, required 1", cal_busy); end
    for (int i = 0; i < 8; i++) send(16'd16, 1'b1);
    m_off = 128;
    m_run = 1'b1;
    n_vec++; if (cal_done !== 1'b1) begin n_err++; $display("FAIL restart_done: got %b, required 1", cal_done); end
    drain();
    moving = 1'b1;
    for (int i = 0; i < 64; i++) send(16'd4144, 1'b1);
    drain();
    n_vec++; if (heading !== 12'd62) begin n_err++; $display("FAIL restart_offset: got %0d, required 62", heading); end
    n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL restart_drain: %0d pending, required 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_reset_mid();
    int n_rdy;
    int n_done;
    moving = 1'b0;
    pulse_strt();
    send(16'd16, 1'b1);
    send(16'd16, 1'b1);
    send(16'd16, 1'b0);
    send(16'd16, 1'b0);
    vld = 1'b1;
    yaw_rt = 16'd16;
    rst = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    rst = 1'b0;
    m_run = 1'b0;
    m_off = 0;
    m_integ = '0;
    n_rdy = 0;
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      if (rdy === 1'b1) n_rdy++;
      if (cal_done === 1'b1) n_done++;
      @(negedge clk);
    end
    n_vec++; if (n_rdy != 0) begin n_err++; $display("FAIL rst_mid_rdy: got %0d pulses, required 0", n_rdy); end
    n_vec++; if (n_done != 0) begin n_err++; $display("FAIL rst_mid_done: got %0d pulses, required 0", n_done); end
    n_vec++; if (cal_busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b, required 0", cal_busy); end
    n_vec++; if (heading !== 12'h000) begin n_err++; $display("FAIL rst_mid_heading: got %h, required 000", heading); end
    n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL rst_mid_queue: %0d pending, required 0", sb.size()); sb.delete(); end
    load_hdg(12'h123);
    n_vec++; if (heading !== 12'h000) begin n_err++; $display("FAIL ld_in_idle: got %h, required 000", heading); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_calibrate();
    test_integrate();
    test_ld_priority();
    test_fusion();
    test_wrap();
    test_cal_err();
    test_restart_final();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/heading_integrator_p.md
HEADING_INTEGRATOR_P -- requirements
Module: heading_integrator_p

Interface
REQ-001 SHALL have the following parameters (name, default, meaning), one per line:
  DATA_W, 16, gyro rate width (signed)
  CAL_LOG2, 11, log2 of calibration sample count (2^CAL_LOG2 samples)
  HEAD_W, 12, heading output width (signed)
  FRAC_W, 15, integrator fractional bits below heading LSB
  SCALE_NUM, 31, rate scale numerator
  SCALE_SHIFT, 5, rate scale denominator exponent (31/32 by default)
  FUSION_GAIN, 12288, per-sample guardrail correction magnitude (integrator LSBs)
  ERR_LIM, 8192, |yaw_rt| limit during calibration
REQ-002 SHALL have the following ports (name, direction, width, meaning), one per line:
  clk, in, 1, sole clock, rising edge
  rst, in, 1, synchronous active-high reset
  strt_cal, in, 1, start or restart calibration
  vld, in, 1, one-cycle strobe, yaw_rt valid
  yaw_rt, in, DATA_W, signed raw yaw rate
  lftIR, in, 1, left guardrail hit
  rghtIR, in, 1, right guardrail hit
  moving, in, 1, integrate enable in RUN
  ld_hdg, in, 1, load heading
  hdg_val, in, HEAD_W, heading load value
  cal_busy, out, 1, high in CAL state
  cal_done, out, 1, one-cycle pulse at end of calibration
  cal_err, out, 1, sticky calibration-sample-out-of-range flag
  rdy, out, 1, heading updated for this sample
  heading, out, HEAD_W, signed heading, wraps modulo 2^HEAD_W

Function
REQ-003 SHALL implement states IDLE, CAL, RUN; IDLE->CAL on strt_cal; CAL->RUN when sample count reaches 2^CAL_LOG2; RUN->CAL on strt_cal; strt_cal in CAL restarts calibration (counter and cal accumulator cleared).
REQ-004 SHALL use a 3-stage pipeline: S1 offset compensation, S2 scaling, S3 integration; rdy SHALL assert exactly 3 cycles after vld, independent of state.
REQ-005 S1: in RUN comp = ({yaw_rt,3'b000}) - yaw_off, width DATA_W+3; in CAL comp = sign-extended {yaw_rt,3'b000}.
REQ-006 S2: scaled = (comp * SCALE_NUM) >>> SCALE_SHIFT, arithmetic shift, truncated to DATA_W+3 bits, captured only on the S1-valid strobe.
REQ-007 Calibration accumulator width DATA_W+3+CAL_LOG2, sums comp of each valid CAL sample; on the final sample yaw_off <= acc >>> CAL_LOG2 (DATA_W+3 bits), cal_done pulses for one cycle, and the heading integrator is cleared.
REQ-008 Heading integrator width HEAD_W+FRAC_W; heading = integ[HEAD_W+FRAC_W-1:FRAC_W]; overflow SHALL wrap, not saturate.
REQ-009 In RUN, on S3 valid with moving=1: integ += scaled + fusion, where fusion = +FUSION_GAIN if lftIR&~rghtIR, -FUSION_GAIN if rghtIR&~lftIR, else 0 (both high = 0).
REQ-010 In RUN with moving=0, integ SHALL hold; rdy still pulses.
REQ-011 In CAL and IDLE, integ SHALL hold at zero; heading reads 0.
REQ-012 ld_hdg in RUN SHALL set integ <= {hdg_val, FRAC_W zeros} next cycle and take priority over a same-cycle S3 update; ld_hdg outside RUN SHALL be ignored.
REQ-013 Any CAL sample with |yaw_rt| > ERR_LIM SHALL set cal_err; cal_err clears only on strt_cal or reset; calibration still completes.
REQ-014 strt_cal coincident with the final CAL sample SHALL restart calibration with no cal_done pulse and yaw_off unchanged.
REQ-015 Samples in flight at a state change SHALL be applied per the state when they reach the consuming stage.

Reset
REQ-016 On rst=1 at a clock edge: state IDLE, yaw_off 0, both accumulators 0, sample counter 0, pipeline valids 0, cal_busy 0, cal_done 0, cal_err 0, rdy 0, heading 0.
REQ-017 Reset asserted mid-calibration or mid-pipeline SHALL discard all in-flight samples; no rdy or cal_done SHALL follow.

Verification (bench uses CAL_LOG2=3, other defaults)
REQ-018 Reset, strt_cal, 8 vld samples yaw_rt=16 -> cal_done pulse, yaw_off=128, state RUN, heading 0.
REQ-019 After REQ-018, moving=1, 4096 vld with yaw_rt=16+32 -> scaled=248 per sample, integ=1015808, heading=31; rdy 3 cycles after each vld.
REQ-020 RUN, yaw_rt=16 (comp 0), lftIR=1 for 8 samples -> heading=3; rghtIR=1 for 8 samples -> heading back to 0; both high -> no change.
REQ-021 RUN, ld_hdg with hdg_val=12'h7FF, then positive rate -> heading wraps to 12'h800; moving=0 -> heading holds.
REQ-022 CAL sample yaw_rt=9000 -> cal_err=1 held through RUN; strt_cal clears it; rst during CAL sample 5 -> IDLE, no cal_done, heading 0.
